// File: rtl/csi2_packet_parser.sv
// CSI-2 packet parser for a 2-lane, byte-aligned 16-bit stream: decodes short/long packet headers and streams payload.
// Optional header ECC checking is enabled by defining CSI2_ECC_CHECK_EN; otherwise the ECC byte is ignored.
module csi2_packet_parser #(
  parameter int LANES = 2
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic [15:0] data_in,
  input  logic        data_valid,
  output logic        frame_start,
  output logic        frame_end,
  output logic        line_start,
  output logic        line_end,
  output logic [15:0] frame_number,
  output logic [1:0]  virtual_channel,
  output logic [5:0]  data_type,
  output logic [15:0] payload,
  output logic [1:0]  payload_keep,
  output logic        payload_valid,
  output logic        packet_done,
  output logic        trunc_err,
  output logic        ecc_err
);

  localparam logic [15:0] STEP = 16'(LANES);

  typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, CRC, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [7:0]  di_q, di_d;
  logic [7:0]  wc_lo_q, wc_lo_d;
  logic [15:0] rem_q, rem_d;
  logic        armed_q, armed_d;

  logic        frame_start_q, frame_start_d;
  logic        frame_end_q, frame_end_d;
  logic        line_start_q, line_start_d;
  logic        line_end_q, line_end_d;
  logic [15:0] frame_number_q, frame_number_d;
  logic [1:0]  vc_q, vc_d;
  logic [5:0]  dt_q, dt_d;
  logic [15:0] payload_q, payload_d;
  logic [1:0]  keep_q, keep_d;
  logic        payload_valid_q, payload_valid_d;
  logic        packet_done_q, packet_done_d;
  logic        trunc_err_q, trunc_err_d;
  logic        ecc_err_q, ecc_err_d;

  logic [15:0] hdr_wc;
  logic        hdr_bad;

  assign hdr_wc = {data_in[7:0], wc_lo_q};

`ifdef CSI2_ECC_CHECK_EN
  // Parity masks over D[23:0] = {WC[15:8], WC[7:0], DI}.
  function automatic logic [5:0] calc_ecc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = ^(d & 24'hF12CB7);
    p[1] = ^(d & 24'hF2555B);
    p[2] = ^(d & 24'h749A6D);
    p[3] = ^(d & 24'hB8E38E);
    p[4] = ^(d & 24'hDF03F0);
    p[5] = ^(d & 24'hEFFC00);
    return p;
  endfunction

  assign hdr_bad = (calc_ecc({hdr_wc, di_q}) != data_in[13:8]);
`else
  assign hdr_bad = 1'b0;
`endif

  always_comb begin
    state_d         = state_q;
    di_d            = di_q;
    wc_lo_d         = wc_lo_q;
    rem_d           = rem_q;
    armed_d         = armed_q | ~data_valid;
    frame_start_d   = 1'b0;
    frame_end_d     = 1'b0;
    line_start_d    = 1'b0;
    line_end_d      = 1'b0;
    frame_number_d  = frame_number_q;
    vc_d            = vc_q;
    dt_d            = dt_q;
    payload_d       = payload_q;
    keep_d          = 2'b00;
    payload_valid_d = 1'b0;
    packet_done_d   = 1'b0;
    trunc_err_d     = 1'b0;
    ecc_err_d       = 1'b0;

    unique case (state_q)
      // After reset, a burst already in flight is skipped until data_valid has been seen low.
      IDLE: begin
        if (data_valid && armed_q) begin
          di_d    = data_in[7:0];
          wc_lo_d = data_in[15:8];
          state_d = HDR;
        end
      end
      HDR: begin
        if (!data_valid) begin
          trunc_err_d = 1'b1;
          state_d     = IDLE;
        end else if (hdr_bad) begin
          ecc_err_d = 1'b1;
          state_d   = DRAIN;
        end else begin
          vc_d = di_q[7:6];
          dt_d = di_q[5:0];
          if (di_q[5:4] == 2'b00) begin
            unique case (di_q[5:0])
              6'h00: begin
                frame_start_d  = 1'b1;
                frame_number_d = hdr_wc;
              end
              6'h01: begin
                frame_end_d    = 1'b1;
                frame_number_d = hdr_wc;
              end
              6'h02: line_start_d = 1'b1;
              6'h03: line_end_d   = 1'b1;
              default: ;
            endcase
            state_d = DRAIN;
          end else if (hdr_wc != 16'd0) begin
            rem_d   = hdr_wc;
            state_d = PAYLOAD;
          end else begin
            state_d = CRC;
          end
        end
      end
      // A final beat carrying a single payload byte has the CRC LSB in its upper byte.
      PAYLOAD: begin
        if (!data_valid) begin
          trunc_err_d = 1'b1;
          rem_d       = 16'd0;
          state_d     = IDLE;
        end else begin
          payload_valid_d = 1'b1;
          payload_d       = data_in;
          keep_d          = (rem_q >= STEP) ? 2'b11 : 2'b01;
          rem_d           = (rem_q > STEP) ? (rem_q - STEP) : 16'd0;
          if (rem_q <= STEP) state_d = CRC;
        end
      end
      CRC: begin
        if (!data_valid) begin
          trunc_err_d = 1'b1;
        end else begin
          packet_done_d = 1'b1;
        end
        state_d = data_valid ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (!data_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      di_q            <= '0;
      wc_lo_q         <= '0;
      rem_q           <= '0;
      armed_q         <= 1'b0;
      frame_start_q   <= 1'b0;
      frame_end_q     <= 1'b0;
      line_start_q    <= 1'b0;
      line_end_q      <= 1'b0;
      frame_number_q  <= '0;
      vc_q            <= '0;
      dt_q            <= '0;
      payload_q       <= '0;
      keep_q          <= '0;
      payload_valid_q <= 1'b0;
      packet_done_q   <= 1'b0;
      trunc_err_q     <= 1'b0;
      ecc_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      di_q            <= di_d;
      wc_lo_q         <= wc_lo_d;
      rem_q           <= rem_d;
      armed_q         <= armed_d;
      frame_start_q   <= frame_start_d;
      frame_end_q     <= frame_end_d;
      line_start_q    <= line_start_d;
      line_end_q      <= line_end_d;
      frame_number_q  <= frame_number_d;
      vc_q            <= vc_d;
      dt_q            <= dt_d;
      payload_q       <= payload_d;
      keep_q          <= keep_d;
      payload_valid_q <= payload_valid_d;
      packet_done_q   <= packet_done_d;
      trunc_err_q     <= trunc_err_d;
      ecc_err_q       <= ecc_err_d;
    end
  end

  assign frame_start     = frame_start_q;
  assign frame_end       = frame_end_q;
  assign line_start      = line_start_q;
  assign line_end        = line_end_q;
  assign frame_number    = frame_number_q;
  assign virtual_channel = vc_q;
  assign data_type       = dt_q;
  assign payload         = payload_q;
  assign payload_keep    = keep_q;
  assign payload_valid   = payload_valid_q;
  assign packet_done     = packet_done_q;
  assign trunc_err       = trunc_err_q;
  assign ecc_err         = ecc_err_q;

endmodule

// File: tb/tb_csi2_packet_parser.sv
// Directed testbench for csi2_packet_parser with an event scoreboard (expected events carry their expected cycle).
// Build with or without CSI2_ECC_CHECK_EN to match the RTL configuration.
module tb_csi2_packet_parser;

`ifdef CSI2_ECC_CHECK_EN
  localparam bit ECC_ON = 1'b1;
`else
  localparam bit ECC_ON = 1'b0;
`endif

  localparam logic [3:0] K_FS = 4'd1, K_FE = 4'd2, K_LS = 4'd3, K_LE = 4'd4;
  localparam logic [3:0] K_PAY = 4'd5, K_DONE = 4'd6, K_TRUNC = 4'd7, K_ECC = 4'd8;

  typedef struct packed {
    logic [3:0]  kind;
    logic [17:0] val;
    logic [31:0] cyc;
  } ev_t;

  logic        clk_in = 1'b0;
  logic        reset;
  logic [15:0] data_in;
  logic        data_valid;
  logic        frame_start, frame_end, line_start, line_end;
  logic [15:0] frame_number;
  logic [1:0]  virtual_channel;
  logic [5:0]  data_type;
  logic [15:0] payload;
  logic [1:0]  payload_keep;
  logic        payload_valid, packet_done, trunc_err, ecc_err;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] cyc = 0;
  ev_t         sb[$];
  logic [15:0] exp_fn = 16'h0;
  logic [1:0]  exp_vc = 2'h0;
  logic [5:0]  exp_dt = 6'h0;

  csi2_packet_parser #(.LANES(2)) dut (
    .clk_in          (clk_in),
    .reset           (reset),
    .data_in         (data_in),
    .data_valid      (data_valid),
    .frame_start     (frame_start),
    .frame_end       (frame_end),
    .line_start      (line_start),
    .line_end        (line_end),
    .frame_number    (frame_number),
    .virtual_channel (virtual_channel),
    .data_type       (data_type),
    .payload         (payload),
    .payload_keep    (payload_keep),
    .payload_valid   (payload_valid),
    .packet_done     (packet_done),
    .trunc_err       (trunc_err),
    .ecc_err         (ecc_err)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Column-syndrome form of the CSI-2 header ECC: each data bit flips a fixed 6-bit pattern.
  function automatic logic [5:0] tb_ecc(input logic [7:0] di, input logic [15:0] wc);
    logic [5:0]  col [24] = '{6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
                              6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
                              6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};
    logic [23:0] d;
    logic [5:0]  e;
    d = {wc, di};
    e = 6'h0;
    for (int i = 0; i < 24; i++) if (d[i]) e = e ^ col[i];
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] k, input logic [17:0] v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    e.cyc  = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic check_evt(input logic [3:0] k, input logic [17:0] v);
    ev_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL unexpected_event observed kind=%0d val=%0h cyc=%0d expected none", k, v, cyc);
    end else begin
      e = sb.pop_front();
      assert (k === e.kind && v === e.val && cyc === e.cyc) else begin
        errors++;
        $error("FAIL event observed kind=%0d val=%0h cyc=%0d expected kind=%0d val=%0h cyc=%0d",
               k, v, cyc, e.kind, e.val, e.cyc);
      end
    end
  endtask

  always @(negedge clk_in) begin
    if (!reset) begin
      if (frame_start)   check_evt(K_FS, {2'b00, frame_number});
      if (frame_end)     check_evt(K_FE, {2'b00, frame_number});
      if (line_start)    check_evt(K_LS, 18'h0);
      if (line_end)      check_evt(K_LE, 18'h0);
      if (payload_valid) check_evt(K_PAY, {payload_keep, payload});
      if (packet_done)   check_evt(K_DONE, 18'h0);
      if (trunc_err)     check_evt(K_TRUNC, 18'h0);
      if (ecc_err)       check_evt(K_ECC, 18'h0);
    end
  end

  task automatic beat(input logic v, input logic [15:0] d);
    data_valid = v;
    data_in    = d;
    @(posedge clk_in);
    #1;
  endtask

  // Two header beats of a short packet, expectations pushed with the HDR beat, then LP.
  task automatic send_short(input logic [7:0] di, input logic [15:0] wc, input logic [7:0] eflip);
    logic [7:0] ecc;
    logic       bad;
    ecc = {2'b00, tb_ecc(di, wc)} ^ eflip;
    bad = (eflip[5:0] != 6'h0);
    beat(1'b1, {wc[7:0], di});
    if (ECC_ON && bad) begin
      push(K_ECC, 18'h0);
    end else begin
      exp_vc = di[7:6];
      exp_dt = di[5:0];
      case (di[5:0])
        6'h00: begin push(K_FS, {2'b00, wc}); exp_fn = wc; end
        6'h01: begin push(K_FE, {2'b00, wc}); exp_fn = wc; end
        6'h02: push(K_LS, 18'h0);
        6'h03: push(K_LE, 18'h0);
        default: ;
      endcase
    end
    beat(1'b1, {ecc, wc[15:8]});
    beat(1'b0, 16'h0);
  endtask

  task automatic long_hdr(input logic [7:0] di, input logic [15:0] wc);
    beat(1'b1, {wc[7:0], di});
    beat(1'b1, {2'b00, tb_ecc(di, wc), wc[15:8]});
    exp_vc = di[7:6];
    exp_dt = di[5:0];
  endtask

  function automatic logic [63:0] out_vec();
    return {14'h0, frame_start, frame_end, line_start, line_end, frame_number, virtual_channel,
            data_type, payload, payload_keep, payload_valid, packet_done, trunc_err, ecc_err};
  endfunction

  initial begin
    reset      = 1'b1;
    data_valid = 1'b0;
    data_in    = 16'h0;
    repeat (3) @(posedge clk_in);
    #1;
    chk("reset_outputs", out_vec(), 64'h0);
    reset = 1'b0;
    beat(1'b0, 16'h0);
    beat(1'b0, 16'h0);

    send_short(8'h00, 16'h0005, 8'h00);
    chk("fs_frame_number", 64'(frame_number), 64'h0005);
    chk("fs_data_type", 64'(data_type), 64'h00);
    chk("fs_vc", 64'(virtual_channel), 64'h0);

    long_hdr(8'h2B, 16'd4);
    push(K_PAY, {2'b11, 16'h2211}); beat(1'b1, 16'h2211);
    push(K_PAY, {2'b11, 16'h4433}); beat(1'b1, 16'h4433);
    push(K_DONE, 18'h0);            beat(1'b1, 16'hBEEF);
    beat(1'b0, 16'h0);
    chk("long4_data_type", 64'(data_type), 64'h2B);

    long_hdr(8'h2A, 16'd3);
    push(K_PAY, {2'b11, 16'h2211}); beat(1'b1, 16'h2211);
    push(K_PAY, {2'b01, 16'hC733}); beat(1'b1, 16'hC733);
    push(K_DONE, 18'h0);            beat(1'b1, 16'h00A5);
    beat(1'b0, 16'h0);

    long_hdr(8'h2B, 16'd8);
    push(K_PAY, {2'b11, 16'h2211}); beat(1'b1, 16'h2211);
    push(K_TRUNC, 18'h0);           beat(1'b0, 16'h0);
    send_short(8'h82, 16'h0010, 8'h00);
    chk("ls_vc", 64'(virtual_channel), 64'h2);
    send_short(8'hC3, 16'h0011, 8'h00);
    chk("le_vc", 64'(virtual_channel), 64'h3);

    send_short(8'h45, 16'h1234, 8'h00);
    chk("dt05_data_type", 64'(data_type), 64'h05);
    chk("dt05_frame_number", 64'(frame_number), 64'(exp_fn));

    send_short(8'h00, 16'h0007, 8'h01);
    chk("eccflip_frame_number", 64'(frame_number), 64'(exp_fn));
    chk("eccflip_data_type", 64'(data_type), 64'(exp_dt));
    chk("eccflip_vc", 64'(virtual_channel), 64'(exp_vc));

    send_short(8'h41, 16'h0009, 8'h00);
    chk("fe_frame_number", 64'(frame_number), 64'h0009);

    long_hdr(8'h12, 16'd0);
    push(K_DONE, 18'h0); beat(1'b1, 16'h1234);
    beat(1'b0, 16'h0);

    beat(1'b1, {8'h00, 8'h2B});
    push(K_TRUNC, 18'h0); beat(1'b0, 16'h0);

    long_hdr(8'h2B, 16'd2);
    push(K_PAY, {2'b11, 16'h5566}); beat(1'b1, 16'h5566);
    push(K_TRUNC, 18'h0);           beat(1'b0, 16'h0);

    // Header-looking beats inside DRAIN must be ignored.
    beat(1'b1, {8'h21, 8'h00});
    push(K_FS, {2'b00, 16'h0021});
    beat(1'b1, {2'b00, tb_ecc(8'h00, 16'h0021), 8'h00});
    beat(1'b1, {8'h05, 8'h01});
    beat(1'b1, {2'b00, tb_ecc(8'h01, 16'h0005), 8'h00});
    beat(1'b0, 16'h0);
    chk("drain_frame_number", 64'(frame_number), 64'h0021);

    long_hdr(8'h6B, 16'd8);
    push(K_PAY, {2'b11, 16'h1111}); beat(1'b1, 16'h1111);
    beat(1'b1, 16'h2222);
    chk("pre_reset_payload_valid", 64'(payload_valid), 64'h1);
    reset = 1'b1;
    #1;
    chk("midpkt_reset_outputs", out_vec(), 64'h0);
    beat(1'b1, 16'h3333);
    beat(1'b1, 16'h3333);
    reset = 1'b0;
    beat(1'b1, 16'h4444);
    beat(1'b1, 16'h4444);
    beat(1'b0, 16'h0);
    send_short(8'h01, 16'h0042, 8'h00);
    chk("post_reset_frame_number", 64'(frame_number), 64'h0042);

    repeat (3) beat(1'b0, 16'h0);
    chk("scoreboard_empty", 64'(sb.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/csi2_packet_parser.md
CSI2_PACKET_PARSER -- requirements
Module: csi2_packet_parser

Interface
REQ-001 SHALL have parameter LANES, default 2, number of D-PHY data lanes merged into data_in; only the value 2 is supported.
REQ-002 SHALL have port clk_in, input, 1 bit: byte clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port data_in, input, 16 bits: aligned lane bytes; [7:0] is the earlier byte.
REQ-005 SHALL have port data_valid, input, 1 bit: high for every beat of one HS burst; low during LP.
REQ-006 SHALL have port frame_start, output, 1 bit: one-cycle pulse on a Frame Start short packet (DT 0x00).
REQ-007 SHALL have port frame_end, output, 1 bit: one-cycle pulse on a Frame End short packet (DT 0x01).
REQ-008 SHALL have port line_start, output, 1 bit: one-cycle pulse on DT 0x02.
REQ-009 SHALL have port line_end, output, 1 bit: one-cycle pulse on DT 0x03.
REQ-010 SHALL have port frame_number, output, 16 bits: WC of the last FS/FE packet.
REQ-011 SHALL have port virtual_channel, output, 2 bits: DI[7:6] of the last accepted header.
REQ-012 SHALL have port data_type, output, 6 bits: DI[5:0] of the last accepted header.
REQ-013 SHALL have port payload, output, 16 bits: long-packet payload bytes, with [7:0] first.
REQ-014 SHALL have port payload_keep, output, 2 bits: byte enables for payload.
REQ-015 SHALL have port payload_valid, output, 1 bit: payload/payload_keep are valid.
REQ-016 SHALL have port packet_done, output, 1 bit: one-cycle pulse after the last CRC byte of a long packet.
REQ-017 SHALL have port trunc_err, output, 1 bit: one-cycle pulse when data_valid falls before the long packet completes.
REQ-018 SHALL have port ecc_err, output, 1 bit: one-cycle pulse on a header with a nonzero ECC syndrome; tied 0 when CSI2_ECC_CHECK_EN is undefined.

Function
REQ-019 SHALL use states IDLE, HDR, PAYLOAD, CRC, DRAIN.
REQ-020 IDLE: on data_valid, SHALL latch DI=data_in[7:0] and WC[7:0]=data_in[15:8], then go to HDR.
REQ-021 HDR: SHALL latch WC[15:8]=data_in[7:0] and ECC=data_in[15:8], then decode on this beat.
  - If data_valid is low in HDR: trunc_err, then IDLE.
REQ-022 Short packet (DT<0x10): SHALL pulse the matching output the cycle after the HDR beat, update frame_number for FS/FE, then go to DRAIN.
  - DT 0x04-0x0F is accepted with no pulse.
REQ-023 Long packet (DT>=0x10), WC>0: SHALL go to PAYLOAD.
  - WC==0: go to CRC.
REQ-024 PAYLOAD: each beat SHALL emit payload_valid one cycle later, with keep=2'b11.
  - Final beat with one remaining byte: keep=2'b01; data_in[15:8] is the CRC LSB.
REQ-025 Remaining-byte counter SHALL be 16 bits, decrement by 2, and never underflow below 0.
REQ-026 CRC: SHALL consume the remaining CRC byte(s) without checking them, pulse packet_done, then go to DRAIN.
  - Even WC: one beat.
  - Odd WC: one beat, using data_in[7:0] only.
REQ-027 DRAIN: SHALL ignore all beats and return to IDLE on the first cycle with data_valid low.
REQ-028 data_valid low in PAYLOAD or CRC SHALL pulse trunc_err, suppress packet_done and return to IDLE.
REQ-029 All outputs SHALL be registered; pulse latency is exactly one cycle after the completing beat.
REQ-030 virtual_channel and data_type SHALL hold until the next accepted header.

Reset
REQ-031 reset SHALL force state IDLE, the counters to 0, and every output to 0, asynchronously.
REQ-032 Reset mid-packet SHALL discard the packet; the next rising data_valid is treated as a new header.

Configuration
REQ-033 CSI2_ECC_CHECK_EN defined: SHALL compute the CSI-2 v1.01 6-bit Hamming ECC over DI,WC and compare it with ECC[5:0].
  - Mismatch: pulse ecc_err, suppress all header-derived pulses, payload and state updates, then go to DRAIN.
REQ-034 CSI2_ECC_CHECK_EN undefined: the ECC byte SHALL be ignored and ecc_err tied 0.

Verification
REQ-035 FS with VC0, WC=0x0005, correct ECC -> frame_start pulses once, frame_number=0x0005, data_type=0x00.
REQ-036 DT=0x2B, WC=4, payload 11 22 33 44, CRC 2 bytes -> payload 0x2211 then 0x4433, keep 11; packet_done one cycle after the CRC beat.
REQ-037 DT=0x2A, WC=3 -> second payload beat keep=01, payload[7:0]=0x33; packet_done after the following beat.
REQ-038 DT=0x2B, WC=8, data_valid drops after the first payload beat -> trunc_err pulse, no packet_done, state IDLE.
REQ-039 FS with ECC bit 0 flipped -> with the macro: ecc_err=1, frame_start=0; without the macro: frame_start=1.
REQ-040 Reset asserted mid-PAYLOAD -> all outputs 0 immediately; the following FE packet pulses frame_end.
